// File: rtl/rf_wb_scheduler.sv
// Register-file write-port scheduler: WB stage wins, long-latency results queue.
// Optional same-cycle bypass of an idle-slot result when RF_WB_BYPASS_EN is defined.
module rf_wb_scheduler #(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_wen,
  input  logic [4:0]  pipe_rd,
  input  logic [31:0] pipe_data,
  input  logic        lu_valid,
  input  logic [4:0]  lu_rd,
  input  logic [31:0] lu_data,
  output logic        lu_ready,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [4:0]  rd_chk,
  output logic        hazard,
  output logic        pipe_hold,
  output logic        rf_wen,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_data
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW = $clog2(MAX_WAIT + 1);

  logic [4:0]    q_rd   [DEPTH];
  logic [31:0]   q_data [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [31:0]   pend, pend_nxt;
  logic [SW-1:0] wait_cnt, wait_nxt;
  logic          slot, empty, full;
  logic          push, pop, byp;
  logic [4:0]    head_rd;

  function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign slot     = pipe_wen && (pipe_rd != 5'd0);
  assign empty    = (cnt == '0);
  assign full     = (cnt == CW'(DEPTH));
  assign lu_ready = !full;
  assign pop      = !slot && !empty;
  assign head_rd  = q_rd[rd_ptr];

`ifdef RF_WB_BYPASS_EN
  assign byp = !slot && empty && lu_valid;
`else
  assign byp = 1'b0;
`endif

  assign push = lu_valid && !full && !byp;

  // slot, pop and byp are mutually exclusive by construction
  always_comb begin
    rf_wen  = 1'b0;
    rf_rd   = pipe_rd;
    rf_data = pipe_data;
    if (!rst) begin
      unique case (1'b1)
        slot: rf_wen = 1'b1;
        pop: begin
          rf_wen  = (head_rd != 5'd0);
          rf_rd   = head_rd;
          rf_data = q_data[rd_ptr];
        end
        byp: begin
          rf_wen  = (lu_rd != 5'd0);
          rf_rd   = lu_rd;
          rf_data = lu_data;
        end
        default: rf_wen = 1'b0;
      endcase
    end
  end

  always_comb begin
    cnt_nxt = cnt;
    if (push && !pop)
      cnt_nxt = cnt + 1'b1;
    else if (pop && !push)
      cnt_nxt = cnt - 1'b1;
  end

  // issue is applied after retirement so a same-register set wins
  always_comb begin
    pend_nxt = pend;
    if (pop)
      pend_nxt[head_rd] = 1'b0;
    if (byp)
      pend_nxt[lu_rd] = 1'b0;
    if (issue_valid)
      pend_nxt[issue_rd] = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  always_comb begin
    wait_nxt = wait_cnt;
    if (pop || empty)
      wait_nxt = '0;
    else if (wait_cnt != SW'(MAX_WAIT))
      wait_nxt = wait_cnt + 1'b1;
  end

  assign hazard = pend[rs1] | pend[rs2] | pend[rd_chk];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      pend      <= '0;
      wait_cnt  <= '0;
      pipe_hold <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= inc_ptr(wr_ptr);
      if (pop)
        rd_ptr <= inc_ptr(rd_ptr);
      cnt       <= cnt_nxt;
      pend      <= pend_nxt;
      wait_cnt  <= wait_nxt;
      pipe_hold <= (wait_nxt == SW'(MAX_WAIT));
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_rd[wr_ptr]   <= lu_rd;
      q_data[wr_ptr] <= lu_data;
    end
  end

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Self-checking bench for rf_wb_scheduler: directed scenarios plus random
// traffic against a queue-based reference model.
module tb_rf_wb_scheduler;

  localparam int DEPTH    = 2;
  localparam int MAX_WAIT = 4;
`ifdef RF_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pipe_wen = 1'b0;
  logic [4:0]  pipe_rd = '0;
  logic [31:0] pipe_data = '0;
  logic        lu_valid = 1'b0;
  logic [4:0]  lu_rd = '0;
  logic [31:0] lu_data = '0;
  logic        lu_ready;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_rd = '0;
  logic [4:0]  rs1 = '0, rs2 = '0, rd_chk = '0;
  logic        hazard, pipe_hold, rf_wen;
  logic [4:0]  rf_rd;
  logic [31:0] rf_data;

  int errors = 0;
  int checks = 0;

  rf_wb_scheduler #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .pipe_wen(pipe_wen), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
    .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_data(lu_data),
    .lu_ready(lu_ready),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rs1(rs1), .rs2(rs2), .rd_chk(rd_chk),
    .hazard(hazard), .pipe_hold(pipe_hold),
    .rf_wen(rf_wen), .rf_rd(rf_rd), .rf_data(rf_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        mq[$];
  bit   [31:0] mpend;
  int          mwait;
  bit          mhold;
  bit          e_wen, e_pop, e_byp;
  logic [4:0]  e_rd;
  logic [31:0] e_data;

  function automatic void model_reset();
    mq.delete();
    mpend = '0;
    mwait = 0;
    mhold = 0;
  endfunction

  function automatic void predict();
    e_wen = 0; e_pop = 0; e_byp = 0; e_rd = '0; e_data = '0;
    if (pipe_wen && pipe_rd != 0) begin
      e_wen = 1; e_rd = pipe_rd; e_data = pipe_data;
    end else if (mq.size() > 0) begin
      e_pop = 1; e_rd = mq[0].rd; e_data = mq[0].data;
      e_wen = (e_rd != 0);
    end else if (BYP && lu_valid) begin
      e_byp = 1; e_rd = lu_rd; e_data = lu_data;
      e_wen = (lu_rd != 0);
    end
  endfunction

  function automatic bit exp_hazard();
    return mpend[rs1] | mpend[rs2] | mpend[rd_chk];
  endfunction

  function automatic void model_update();
    bit was_empty, ready;
    ent_t e;
    predict();
    was_empty = (mq.size() == 0);
    ready = (mq.size() < DEPTH);
    if (e_pop) begin
      void'(mq.pop_front());
      if (e_rd != 0) mpend[e_rd] = 0;
    end
    if (e_byp && lu_rd != 0) mpend[lu_rd] = 0;
    if (lu_valid && ready && !e_byp) begin
      e.rd = lu_rd; e.data = lu_data;
      mq.push_back(e);
    end
    if (issue_valid && issue_rd != 0) mpend[issue_rd] = 1;
    if (e_pop || was_empty) mwait = 0;
    else if (mwait < MAX_WAIT) mwait++;
    mhold = (mwait == MAX_WAIT);
  endfunction

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_idle();
    pipe_wen = 0; pipe_rd = 0; pipe_data = 0;
    lu_valid = 0; lu_rd = 0; lu_data = 0;
    issue_valid = 0; issue_rd = 0;
    rs1 = 0; rs2 = 0; rd_chk = 0;
  endtask

  task automatic apply_reset();
    set_idle();
    rst = 1;
    model_reset();
    @(posedge clk);
    #1 rst = 0;
    #1;
  endtask

  task automatic test_reset();
    set_idle();
    rst = 1;
    model_reset();
    pipe_wen = 1; pipe_rd = 3; pipe_data = 32'h55;
    #1;
    checks++;
    if (rf_wen !== 1'b0) begin
      errors++; $display("FAIL reset_rf_wen: got %b want 0", rf_wen);
    end
    checks++;
    if (lu_ready !== 1'b1) begin
      errors++; $display("FAIL reset_lu_ready: got %b want 1", lu_ready);
    end
    checks++;
    if (hazard !== 1'b0 || pipe_hold !== 1'b0) begin
      errors++;
      $display("FAIL reset_hz_hold: got %b%b want 00", hazard, pipe_hold);
    end
    @(posedge clk);
    #1 rst = 0;
    set_idle();
    #1;
  endtask

  task automatic test_idle_drain();
    int wcyc;
    apply_reset();
    issue_valid = 1; issue_rd = 5;
    tick();
    issue_valid = 0;
    wcyc = -1;
    lu_valid = 1; lu_rd = 5; lu_data = 32'hDEADBEEF;
    #1;
    if (rf_wen && rf_rd == 5 && rf_data == 32'hDEADBEEF) wcyc = 0;
    tick();
    lu_valid = 0;
    #1;
    if (wcyc < 0 && rf_wen && rf_rd == 5 && rf_data == 32'hDEADBEEF)
      wcyc = 1;
    checks++;
    if (wcyc !== (BYP ? 0 : 1)) begin
      errors++;
      $display("FAIL drain_latency: got %0d want %0d", wcyc, BYP ? 0 : 1);
    end
    tick();
    rs1 = 5;
    #1;
    checks++;
    if (hazard !== 1'b0) begin
      errors++; $display("FAIL drain_pend5: got %b want 0", hazard);
    end
  endtask

  task automatic test_priority();
    logic [4:0] want_rd [5];
    apply_reset();
    want_rd = '{5'd3, 5'd3, 5'd3, 5'd7, 5'd8};
    for (int c = 0; c < 5; c++) begin
      pipe_wen = (c < 3); pipe_rd = 3; pipe_data = 32'h11;
      lu_valid = (c < 2);
      lu_rd = (c == 0) ? 5'd7 : 5'd8;
      lu_data = (c == 0) ? 32'h77 : 32'h88;
      #1;
      checks++;
      if (rf_wen !== 1'b1 || rf_rd !== want_rd[c]) begin
        errors++;
        $display("FAIL prio_c%0d: got wen=%b rd=%0d want wen=1 rd=%0d",
                 c, rf_wen, rf_rd, want_rd[c]);
      end
      if (c == 2) begin
        checks++;
        if (lu_ready !== 1'b0) begin
          errors++; $display("FAIL prio_full: got %b want 0", lu_ready);
        end
      end
      tick();
    end
    set_idle();
    #1;
    checks++;
    if (rf_wen !== 1'b0 || lu_ready !== 1'b1) begin
      errors++;
      $display("FAIL prio_drained: got wen=%b rdy=%b want 0 1", rf_wen, lu_ready);
    end
  endtask

  task automatic test_starvation();
    apply_reset();
    pipe_wen = 1; pipe_rd = 3; pipe_data = 32'h33;
    lu_valid = 1; lu_rd = 6; lu_data = 32'h66;
    tick();
    lu_valid = 0;
    for (int k = 1; k <= 6; k++) begin
      #1;
      checks++;
      if (pipe_hold !== (k >= 5)) begin
        errors++;
        $display("FAIL starve_k%0d: got %b want %b", k, pipe_hold, k >= 5);
      end
      tick();
    end
    pipe_wen = 0;
    #1;
    checks++;
    if (pipe_hold !== 1'b1 || rf_wen !== 1'b1 || rf_rd !== 5'd6) begin
      errors++;
      $display("FAIL starve_pop: got hold=%b wen=%b rd=%0d want 1 1 6",
               pipe_hold, rf_wen, rf_rd);
    end
    tick();
    checks++;
    if (pipe_hold !== 1'b0) begin
      errors++; $display("FAIL starve_release: got %b want 0", pipe_hold);
    end
  endtask

  task automatic test_hazard();
    apply_reset();
    issue_valid = 1; issue_rd = 9; rs1 = 9;
    #1;
    checks++;
    if (hazard !== 1'b0) begin
      errors++; $display("FAIL hz_same_cycle: got %b want 0", hazard);
    end
    tick();
    issue_valid = 0;
    #1;
    checks++;
    if (hazard !== 1'b1) begin
      errors++; $display("FAIL hz_set: got %b want 1", hazard);
    end
    rs1 = 10;
    #1;
    checks++;
    if (hazard !== 1'b0) begin
      errors++; $display("FAIL hz_other: got %b want 0", hazard);
    end
    rs1 = 9;
    lu_valid = 1; lu_rd = 9; lu_data = 32'h99;
    tick();
    lu_valid = 0;
    #1;
    checks++;
    if (hazard !== !BYP || rf_wen !== !BYP) begin
      errors++;
      $display("FAIL hz_retire: got hz=%b wen=%b want %b %b",
               hazard, rf_wen, !BYP, !BYP);
    end
    tick();
    checks++;
    if (hazard !== 1'b0) begin
      errors++; $display("FAIL hz_cleared: got %b want 0", hazard);
    end
  endtask

  task automatic test_same_cycle();
    apply_reset();
    issue_valid = 1; issue_rd = 4;
    tick();
    issue_valid = BYP; rd_chk = 4;
    lu_valid = 1; lu_rd = 4; lu_data = 32'h44;
    tick();
    lu_valid = 0;
    issue_valid = !BYP;
    #1;
    checks++;
    if (rf_wen !== !BYP) begin
      errors++; $display("FAIL same_pop: got %b want %b", rf_wen, !BYP);
    end
    tick();
    issue_valid = 0;
    #1;
    checks++;
    if (hazard !== 1'b1) begin
      errors++; $display("FAIL same_set_wins: got %b want 1", hazard);
    end
  endtask

  task automatic test_x0();
    apply_reset();
    lu_valid = 1; lu_rd = 0; lu_data = 32'h123;
    #1;
    checks++;
    if (rf_wen !== 1'b0) begin
      errors++; $display("FAIL x0_push: got %b want 0", rf_wen);
    end
    tick();
    lu_rd = 2; lu_data = 32'h222;
    #1;
    checks++;
    if (rf_wen !== BYP) begin
      errors++; $display("FAIL x0_pop: got %b want %b", rf_wen, BYP);
    end
    tick();
    lu_valid = 0;
    #1;
    checks++;
    if (rf_wen !== !BYP) begin
      errors++; $display("FAIL x0_next: got %b want %b", rf_wen, !BYP);
    end
    tick();
    checks++;
    if (rf_wen !== 1'b0 || lu_ready !== 1'b1) begin
      errors++;
      $display("FAIL x0_empty: got wen=%b rdy=%b want 0 1", rf_wen, lu_ready);
    end
  endtask

  task automatic test_reset_midflight();
    apply_reset();
    pipe_wen = 1; pipe_rd = 3; pipe_data = 32'h1;
    lu_valid = 1; lu_rd = 12; lu_data = 32'hC;
    issue_valid = 1; issue_rd = 12;
    tick();
    issue_valid = 0;
    lu_rd = 13; lu_data = 32'hD;
    tick();
    lu_valid = 0; rs1 = 12;
    #1;
    checks++;
    if (lu_ready !== 1'b0 || hazard !== 1'b1) begin
      errors++;
      $display("FAIL mid_full: got rdy=%b hz=%b want 0 1", lu_ready, hazard);
    end
    #2 rst = 1;
    model_reset();
    #1;
    checks++;
    if (lu_ready !== 1'b1 || hazard !== 1'b0 || rf_wen !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got rdy=%b hz=%b wen=%b want 1 0 0",
               lu_ready, hazard, rf_wen);
    end
    @(posedge clk);
    #1 rst = 0;
    pipe_wen = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (rf_wen !== 1'b0) begin
        errors++; $display("FAIL mid_after_c%0d: got %b want 0", c, rf_wen);
      end
      tick();
    end
  endtask

  task automatic test_random();
    int pct;
    logic [4:0] r;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      case (i / 100)
        0: pct = 30;
        1: pct = 95;
        2: pct = 60;
        default: pct = 85;
      endcase
      pipe_wen = ($urandom_range(0, 99) < pct);
      pipe_rd = 5'($urandom_range(0, 31));
      pipe_data = $urandom;
      lu_valid = ($urandom_range(0, 2) == 0);
      lu_rd = 5'($urandom_range(0, 31));
      lu_data = $urandom;
      r = 5'($urandom_range(1, 31));
      issue_valid = ($urandom_range(0, 3) == 0) && !mpend[r];
      issue_rd = r;
      rs1 = 5'($urandom_range(0, 31));
      rs2 = 5'($urandom_range(0, 31));
      rd_chk = 5'($urandom_range(0, 31));
      #1;
      predict();
      checks++;
      if (rf_wen !== e_wen ||
          (e_wen && (rf_rd !== e_rd || rf_data !== e_data))) begin
        errors++;
        $display("FAIL rnd_write_%0d: got %b/%0d/%h want %b/%0d/%h",
                 i, rf_wen, rf_rd, rf_data, e_wen, e_rd, e_data);
      end
      checks++;
      if (lu_ready !== (mq.size() < DEPTH)) begin
        errors++;
        $display("FAIL rnd_ready_%0d: got %b want %b",
                 i, lu_ready, mq.size() < DEPTH);
      end
      checks++;
      if (hazard !== exp_hazard()) begin
        errors++;
        $display("FAIL rnd_hazard_%0d: got %b want %b", i, hazard, exp_hazard());
      end
      checks++;
      if (pipe_hold !== mhold) begin
        errors++;
        $display("FAIL rnd_hold_%0d: got %b want %b", i, pipe_hold, mhold);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_idle_drain();
    test_priority();
    test_starvation();
    test_hazard();
    test_same_cycle();
    test_x0();
    test_reset_midflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
